fetch_sequencer: RTL

Instruction-fetch controller that drives the program counter and consumes its address. It drives `ld_pc`/`inc_pc` into the program counter and reads `adpc` back. It issues a request/acknowledge read to instruction memory at that address and latches the returned word into an instruction register. It then presents the word to the decoder with a valid/ready handshake. It sits between the program counter, instruction memory and decode stage.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_timeout_counter.sv | 31 +++
 rtl/fetch_sequencer.sv | 114 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// FETCH_TIMEOUT_EN enables the memory wait timeout and the FAULT state.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_HALTED,
    S_FAULT
  } state_e;

  localparam int AW_DEF       = 5;
  localparam int DW_DEF       = 32;
  localparam int WAIT_MAX_DEF = 15;
  localparam int WAIT_W       = 8;

  localparam logic [DW_DEF-1:0] NOP = '0;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory read and decoder handshake bundle of the fetch sequencer.
// master: the sequencer side; slave: the memory/decoder side.
interface fetch_sequencer_if #(
  parameter int AW = 5,
  parameter int DW = 32
);

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] ir;
  logic          ir_valid;
  logic          ir_ready;

  modport master (
    output mem_req, mem_addr,
    output ir, ir_valid,
    input  mem_ack, mem_rdata,
    input  ir_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    input  ir, ir_valid,
    output mem_ack, mem_rdata,
    output ir_ready
  );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Memory wait counter: clears on clr_i, counts on en_i, saturates at term_o.
module fetch_timeout_counter #(
  parameter int W   = 8,
  parameter int MAX = 15
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // term marks the last permitted wait cycle (cycle MAX of REQ)
  assign term_o = (cnt_q == W'(MAX - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !term_o)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: PC run/increment, memory read, IR and decode handshake.
// FETCH_TIMEOUT_EN adds a wait timeout that parks the unit in FAULT.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  input  logic [AW-1:0] adpc,
  output logic          ld_pc,
  output logic          inc_pc,
  output logic          wrap,
  output logic          fault,
  fetch_sequencer_if.master bus
);

  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait
    $error("WAIT_MAX out of range");
  end

  state_e        state_q, state_d;
  logic [DW-1:0] ir_q;
  logic          inc_q;
  logic          wrap_q;
  logic          to_fault;
  logic          capture;

  assign capture = (state_q == S_REQ) && bus.mem_ack;

`ifdef FETCH_TIMEOUT_EN
  logic wait_clr, wait_en;

  assign wait_clr = (state_d == S_REQ) && (state_q != S_REQ);
  assign wait_en  = (state_q == S_REQ) && !bus.mem_ack;

  fetch_timeout_counter #(
    .W  (WAIT_W),
    .MAX(WAIT_MAX)
  ) u_wait (
    .pclk  (pclk),
    .rst   (rst),
    .clr_i (wait_clr),
    .en_i  (wait_en),
    .term_o(to_fault)
  );

  assign fault = (state_q == S_FAULT);
`else
  assign to_fault = 1'b0;
  assign fault    = 1'b0;
`endif

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ack wins over the timeout on the limit cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_REQ;
      S_REQ: begin
        if (bus.mem_ack)  state_d = S_VALID;
        else if (to_fault) state_d = S_FAULT;
      end
      S_VALID: begin
        if (bus.ir_ready)
          state_d = halt ? S_HALTED : S_REQ;
      end
      S_HALTED: if (start) state_d = S_REQ;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_pc        = 1'b1;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    bus.ir_valid = 1'b0;
    unique case (state_q)
      S_IDLE: ld_pc = 1'b0;
      S_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = adpc;
      end
      S_VALID: bus.ir_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      ir_q   <= DW'(NOP);
      inc_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      inc_q  <= capture;
      wrap_q <= capture && (&adpc);
      if (capture) ir_q <= bus.mem_rdata;
    end
  end

  assign bus.ir = ir_q;
  assign inc_pc = inc_q;
  assign wrap   = wrap_q;

endmodule
